// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter feeding the register file write port; optional
// round-robin arbitration with `define WB_RR_ARB_EN (fixed priority p0>p1 otherwise).

module regfile_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [4:0]      push_rd,
    input  logic [XLEN-1:0] push_data,
    output logic            ready,
    output logic            empty,
    output logic [4:0]      head_rd,
    output logic [XLEN-1:0] head_data,
    output logic [31:0]     mask
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]      rd_mem  [DEPTH];
    logic [XLEN-1:0] dat_mem [DEPTH];
    logic [AW-1:0]   wptr, rptr, off;
    logic [AW:0]     count;

    assign ready     = (count != FULL);
    assign empty     = (count == '0);
    assign head_rd   = rd_mem[rptr];
    assign head_data = dat_mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wptr]  <= push_rd;
            dat_mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        mask = '0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rptr;
            if ({1'b0, off} < count) mask[rd_mem[i]] = 1'b1;
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            p0_valid,
    output logic            p0_ready,
    input  logic [4:0]      p0_rd,
    input  logic [XLEN-1:0] p0_data,
    input  logic            p1_valid,
    output logic            p1_ready,
    input  logic [4:0]      p1_rd,
    input  logic [XLEN-1:0] p1_data,
    output logic            rf_we,
    output logic [4:0]      rf_a3,
    output logic [XLEN-1:0] rf_wd,
    output logic [31:0]     pend_mask
);
    logic            push0, push1, grant0, grant1, empty0, empty1;
    logic [4:0]      head_rd0, head_rd1;
    logic [XLEN-1:0] head_data0, head_data1;
    logic [31:0]     mask0, mask1, stage_mask;

    // Writes to x0 are accepted but dropped before they reach the FIFO.
    assign push0 = p0_valid && p0_ready && (p0_rd != 5'd0);
    assign push1 = p1_valid && p1_ready && (p1_rd != 5'd0);

    regfile_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo0 (
        .clk(clk), .rst(rst), .push(push0), .pop(grant0),
        .push_rd(p0_rd), .push_data(p0_data), .ready(p0_ready), .empty(empty0),
        .head_rd(head_rd0), .head_data(head_data0), .mask(mask0)
    );

    regfile_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .pop(grant1),
        .push_rd(p1_rd), .push_data(p1_data), .ready(p1_ready), .empty(empty1),
        .head_rd(head_rd1), .head_data(head_data1), .mask(mask1)
    );

`ifdef WB_RR_ARB_EN
    logic rr_last;  // 1: port 1 was granted last, so port 0 wins the next tie

    always_comb begin
        grant0 = !empty0 && (empty1 || rr_last);
        grant1 = !empty1 && (empty0 || !rr_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_last <= 1'b1;
        else if (grant0) rr_last <= 1'b0;
        else if (grant1) rr_last <= 1'b1;
    end
`else
    always_comb begin
        grant0 = !empty0;
        grant1 = !empty1 && empty0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= grant0 || grant1;
            if (grant0) begin
                rf_a3 <= head_rd0;
                rf_wd <= head_data0;
            end else if (grant1) begin
                rf_a3 <= head_rd1;
                rf_wd <= head_data1;
            end
        end
    end

    assign stage_mask = rf_we ? (32'd1 << rf_a3) : 32'd0;
    assign pend_mask  = (mask0 | mask1 | stage_mask) & ~32'd1;
endmodule
